// File: rtl/menu_pkg.sv
// Shared types and colour constants for the title-menu controller.
package menu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE,
        ST_WAIT_READY,
        ST_RUN
    } state_t;

    localparam logic [23:0] HILITE = 24'hFFD000;
    localparam logic [23:0] BOX    = 24'h4060FF;
    localparam logic [23:0] BG     = 24'h00FFFF;

endpackage

// File: rtl/menu_key_edge.sv
// Rising-edge detector for one synchronous key level: pulses for the first cycle the key reads high.
module menu_key_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/menu_ctrl.sv
// Title menu: cursor over N_OPT option boxes, selection latch, fade-out and hand-off to the game engine.
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int N_OPT       = 3,
    parameter int FADE_CYCLES = 60000000,
    parameter int CORDW       = 16,
    parameter int H_RES       = 800,
    parameter int V_RES       = 600,
    parameter int OPT_X0      = 300,
    parameter int OPT_Y0      = 360,
    parameter int OPT_W       = 200,
    parameter int OPT_H       = 32,
    parameter int OPT_GAP     = 12,
    localparam int MW         = (N_OPT > 1) ? $clog2(N_OPT) : 1
) (
    input  logic                    i_clk_pix,
    input  logic                    i_rst,
    input  logic signed [CORDW-1:0] i_sx,
    input  logic signed [CORDW-1:0] i_sy,
    input  logic                    i_key_up,
    input  logic                    i_key_down,
    input  logic                    i_key_sel,
    input  logic                    i_main_ready,
    input  logic                    i_return_menu,
    output logic                    o_main_start,
    output logic [MW-1:0]           o_mode,
    output logic                    o_processing,
    output logic [3:0]              o_fade,
    output logic                    o_drawing,
    output logic [7:0]              o_red,
    output logic [7:0]              o_green,
    output logic [7:0]              o_blue
);

    localparam int STEPS = FADE_CYCLES / 16;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);
    localparam logic [MW-1:0] CUR_LAST  = MW'(N_OPT - 1);

    localparam logic signed [CORDW-1:0] X_LO  = CORDW'(OPT_X0);
    localparam logic signed [CORDW-1:0] X_HI  = CORDW'(OPT_X0 + OPT_W);
    localparam logic signed [CORDW-1:0] X_LIM = CORDW'(H_RES);
    localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(V_RES);

    function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [3:0] f);
        logic [11:0] prod;
        prod = 12'(c) * 12'(f);
        return c - prod[11:4];
    endfunction

    logic up_rise, down_rise, sel_rise;

    menu_key_edge u_up   (.clk(i_clk_pix), .rst(i_rst), .level(i_key_up),   .rise(up_rise));
    menu_key_edge u_down (.clk(i_clk_pix), .rst(i_rst), .level(i_key_down), .rise(down_rise));
    menu_key_edge u_sel  (.clk(i_clk_pix), .rst(i_rst), .level(i_key_sel),  .rise(sel_rise));

    state_t          state_q, state_d;
    logic [MW-1:0]   cursor_q, cursor_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic [3:0]      fade_q, fade_d;
    logic [SW-1:0]   step_q, step_d;

    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            mode_q   <= '0;
            fade_q   <= '0;
            step_q   <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            mode_q   <= mode_d;
            fade_q   <= fade_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        mode_d   = mode_q;
        fade_d   = fade_q;
        step_d   = step_q;
        case (state_q)
            ST_IDLE: begin
                // Select wins over any simultaneous cursor key and leaves the cursor alone
                if (sel_rise) begin
                    mode_d  = cursor_q;
                    state_d = ST_FADE;
                    step_d  = '0;
                    fade_d  = '0;
                end else if (up_rise && !down_rise) begin
                    cursor_d = (cursor_q == '0) ? CUR_LAST : cursor_q - MW'(1);
                end else if (down_rise && !up_rise) begin
                    cursor_d = (cursor_q == CUR_LAST) ? '0 : cursor_q + MW'(1);
                end
            end
            ST_FADE: begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (fade_q == 4'hF) state_d = i_main_ready ? ST_RUN : ST_WAIT_READY;
                    else                fade_d  = fade_q + 4'd1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            ST_WAIT_READY: begin
                fade_d = 4'hF;
                if (i_main_ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_return_menu) begin
                    state_d = ST_IDLE;
                    fade_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_main_start = (state_q == ST_RUN);
    assign o_processing = (state_q != ST_RUN);
    assign o_mode       = mode_q;
    assign o_fade       = fade_q;

    logic                    hit_any, hit_cur;
    logic signed [CORDW-1:0] y_lo, y_hi;
    logic                    in_x;

    always_comb begin
        hit_any = 1'b0;
        hit_cur = 1'b0;
        y_lo    = '0;
        y_hi    = '0;
        in_x    = (i_sx >= X_LO) && (i_sx < X_HI) && (i_sx < X_LIM);
        for (int i = 0; i < N_OPT; i++) begin
            y_lo = CORDW'(OPT_Y0 + i * (OPT_H + OPT_GAP));
            y_hi = y_lo + CORDW'(OPT_H);
            if (in_x && (i_sy >= y_lo) && (i_sy < y_hi) && (i_sy < Y_LIM)) begin
                hit_any = 1'b1;
                if (cursor_q == MW'(i)) hit_cur = 1'b1;
            end
        end
    end

    logic [23:0] base_p0;
    logic [23:0] rgb_p0;
    logic        drawing_p0;

    always_comb begin
        base_p0    = hit_cur ? HILITE : (hit_any ? BOX : BG);
        rgb_p0     = {fade_ch(base_p0[23:16], fade_q),
                      fade_ch(base_p0[15:8],  fade_q),
                      fade_ch(base_p0[7:0],   fade_q)};
        drawing_p0 = hit_any;
        if (state_q == ST_RUN) begin
            rgb_p0     = '0;
            drawing_p0 = 1'b0;
        end
    end

    // p0 -> p1: pixel outputs registered one clock after the coordinate
    always_ff @(posedge i_clk_pix or posedge i_rst) begin
        if (i_rst) begin
            o_drawing <= 1'b0;
            o_red     <= '0;
            o_green   <= '0;
            o_blue    <= '0;
        end else begin
            o_drawing <= drawing_p0;
            o_red     <= rgb_p0[23:16];
            o_green   <= rgb_p0[15:8];
            o_blue    <= rgb_p0[7:0];
        end
    end

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with a short fade (FADE_CYCLES = 32, two clocks per fade level).
module tb_menu_ctrl;

    localparam int N_OPT = 3;
    localparam int MW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [15:0] sx, sy;
    logic              ku, kd, ks, ready, ret;
    logic              main_start, processing, drawing;
    logic [MW-1:0]     mode;
    logic [3:0]        fade;
    logic [7:0]        red, green, blue;

    int n_cmp = 0;
    int n_bad = 0;

    menu_ctrl #(.N_OPT(N_OPT), .FADE_CYCLES(32)) dut (
        .i_clk_pix(clk), .i_rst(rst), .i_sx(sx), .i_sy(sy),
        .i_key_up(ku), .i_key_down(kd), .i_key_sel(ks),
        .i_main_ready(ready), .i_return_menu(ret),
        .o_main_start(main_start), .o_mode(mode), .o_processing(processing),
        .o_fade(fade), .o_drawing(drawing),
        .o_red(red), .o_green(green), .o_blue(blue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        ku = u; kd = d; ks = s;
        step();
        ku = 1'b0; kd = 1'b0; ks = 1'b0;
    endtask

    task automatic check_cursor(input string tag, input int exp);
        for (int k = 0; k < N_OPT; k++) begin
            sx = 16'sd310;
            sy = 16'(370 + 44 * k);
            step();
            chk(tag, {8'h0, red, green, blue}, (k == exp) ? 32'hFFD000 : 32'h4060FF);
        end
    endtask

    logic seen_start;

    initial begin
        rst = 1'b1; sx = '0; sy = '0;
        ku = 1'b0; kd = 1'b0; ks = 1'b0; ready = 1'b1; ret = 1'b0;
        #2;
        chk("rst_start", main_start, 0);
        chk("rst_proc",  processing, 1);
        chk("rst_fade",  fade, 0);
        chk("rst_mode",  mode, 0);
        chk("rst_draw",  drawing, 0);
        chk("rst_rgb",   {red, green, blue}, 0);
        #10 rst = 1'b0;
        step();
        chk("proc_after_rel", processing, 1);

        sx = 16'sd0; sy = 16'sd0;
        step();
        chk("bg_draw", drawing, 0);
        chk("bg_rgb",  {red, green, blue}, 32'h00FFFF);
        sx = -16'sd200; sy = 16'sd370;
        step();
        chk("neg_draw", drawing, 0);

        check_cursor("cur0", 0);
        press(0, 1, 0); check_cursor("down1", 1);
        press(0, 1, 0); check_cursor("down2", 2);
        press(0, 1, 0); check_cursor("down3", 0);
        press(0, 1, 0); check_cursor("down4", 1);
        press(1, 0, 0); check_cursor("up_to0", 0);
        press(1, 0, 0); check_cursor("up_wrap", 2);
        press(0, 1, 0); check_cursor("down_wrap", 0);

        kd = 1'b1;
        repeat (10) step();
        kd = 1'b0;
        check_cursor("held_down", 1);

        press(1, 1, 0); check_cursor("up_down_same", 1);

        // up + select together: select wins, mode = 1
        ready = 1'b1;
        press(1, 0, 1);
        chk("sel_mode", mode, 1);
        chk("sel_fade0", fade, 0);
        chk("sel_proc", processing, 1);
        sx = 16'sd310; sy = 16'sd370;
        for (int e = 1; e <= 32; e++) begin
            step();
            if (e <= 4 || e == 30) chk("fade_lvl", fade, 32'(e / 2));
            if (e == 31) chk("fade_no_start", main_start, 0);
            if (e == 32) begin
                chk("run_start", main_start, 1);
                chk("run_proc", processing, 0);
                chk("fade15_box", {red, green, blue}, 32'h040610);
            end
        end
        step();
        chk("run_draw", drawing, 0);
        chk("run_rgb", {red, green, blue}, 0);

        ret = 1'b1; step(); ret = 1'b0;
        chk("ret_start", main_start, 0);
        chk("ret_proc", processing, 1);
        chk("ret_fade", fade, 0);
        check_cursor("ret_cursor", 1);
        press(1, 0, 0); check_cursor("hilite_box0", 0);

        // second fade with engine not ready
        ready = 1'b0;
        press(0, 0, 1);
        chk("sel2_mode", mode, 0);
        repeat (32) step();
        chk("wait_start", main_start, 0);
        chk("wait_fade", fade, 15);
        chk("wait_proc", processing, 1);
        sx = 16'sd310; sy = 16'sd370;
        ret = 1'b1; step(); ret = 1'b0;
        chk("wait_hilite", {red, green, blue}, 32'h100D00);
        chk("wait_ret_ign", main_start, 0);
        chk("wait_fade_hold", fade, 15);
        ready = 1'b1; step();
        chk("ready_start", main_start, 1);

        press(0, 1, 0);
        ret = 1'b1; step(); ret = 1'b0;
        chk("ret2_start", main_start, 0);
        check_cursor("keys_ign_run", 0);

        // reset mid-fade at level 7
        press(0, 1, 0);
        press(0, 0, 1);
        chk("sel3_mode", mode, 1);
        sx = 16'sd310; sy = 16'sd370;
        repeat (14) step();
        chk("mid_fade7", fade, 7);
        chk("mid_draw", drawing, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_fade", fade, 0);
        chk("arst_mode", mode, 0);
        chk("arst_start", main_start, 0);
        chk("arst_proc", processing, 1);
        chk("arst_draw", drawing, 0);
        chk("arst_rgb", {red, green, blue}, 0);
        @(negedge clk) rst = 1'b0;
        seen_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (main_start) seen_start = 1'b1;
        end
        chk("no_start_leak", seen_start, 0);
        check_cursor("cursor_after_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
